udma_cdc_tx_arbiter: RTL and testbench
======================================

// Module: udma_cdc_tx_arbiter
// PURPOSE
//  Round-robin, burst-locked arbiter sharing one CDC FIFO source port among N_CH uDMA TX channels.
//  Sits in the uDMA clock domain in front of udma_dc_fifo.src_*; tags each beat with its channel ID
//  so the peripheral-side consumer can demux. Registered output, one beat/cycle sustained.
// PARAMETERS
//  N_CH        4   number of requesting channels (>=2)
//  DATA_WIDTH  32  payload width per beat
//  MAX_BURST   4   max beats granted to one channel before re-arbitration (>=1)
// PORTS
//  clk_i        in   1                       uDMA clock
//  rstn_i       in   1                       asynchronous active-low reset
//  cfg_en_i     in   1                       arbiter enable; 0 = no new bursts start
//  ch_data_i    in   N_CH x DATA_WIDTH       per-channel payload
//  ch_last_i    in   N_CH                    per-channel last beat of transfer (ends burst early)
//  ch_valid_i   in   N_CH                    per-channel valid
//  ch_ready_o   out  N_CH                    per-channel ready (at most one bit high)
//  fifo_data_o  out  ID_W+DATA_WIDTH         {ch_id, payload} to dc-fifo src_data_i
//  fifo_valid_o out  1                       to dc-fifo src_valid_i
//  fifo_ready_i in   1                       from dc-fifo src_ready_o
//  busy_o       out  1                       1 while in BURST or output register full
//  grant_id_o   out  ID_W                    currently/last granted channel
// BEHAVIOUR
//  - Reset: state=IDLE, rr_ptr=0, beat_cnt=0, fifo_valid_o=0, fifo_data_o=0, ch_ready_o=0,
//    busy_o=0, grant_id_o=0. Reset mid-burst discards the held output beat.
//  - ID_W = max(1,$clog2(N_CH)). Handshakes are AXI-style: valid must not depend on ready.
//  - Output register (1 entry): loads when empty or fifo_ready_i=1 this cycle; fifo_valid_o
//    clears when drained and nothing loaded. Latency ch handshake -> fifo_valid_o = 1 cycle.
//  - ch_ready_o[g] = (state==BURST) & (grant==g) & (out_empty | fifo_ready_i); all others 0.
//  - FSM IDLE: if cfg_en_i & |ch_valid_i, pick first valid channel searching rr_ptr, rr_ptr+1, ...
//    modulo N_CH; grant<=winner, beat_cnt<=0, go BURST (arbitration costs 1 cycle, no beat).
//  - FSM BURST: each accepted beat increments beat_cnt. Exit to IDLE after the accepted beat when
//    beat_cnt==MAX_BURST-1 or ch_last_i[g]=1; also exit if ch_valid_i[g]=0 while ready would be 1.
//    On exit rr_ptr <= (g+1) mod N_CH (wrap at N_CH-1 -> 0).
//  - cfg_en_i=0 during BURST: current burst completes normally; no new grant afterwards.
//  - Output full & fifo_ready_i=0: burst stalls, beat_cnt held, grant held indefinitely.
//  - Simultaneous requests: strictly round-robin; no channel waits more than N_CH-1 bursts.
// CONFIGURATION
//  UDMA_TX_ARB_PRIO_EN defined: channel 0 is high priority -- in IDLE, if ch_valid_i[0]=1 it wins
//    regardless of rr_ptr; rr_ptr not updated after a ch0 burst (others keep RR order).
//  Undefined: pure round-robin as above; ch0 treated like any channel.
// STRUCTURE
//  udma_tx_arb_pkg: arb_state_e {IDLE, BURST}, ID_W function, beat_t struct {id, data}.
//  One sub-module: udma_rr_pick (N_CH-wide rotate-priority encoder, inputs req+ptr, out idx+found).
//  FSM, counter, output register kept in top module.
// TESTING
//  1 single ch2 sends 3 beats with last on beat 3, fifo_ready=1 -> 3 beats out id=2, back to IDLE, rr_ptr=3.
//  2 all 4 ch valid continuously, MAX_BURST=4 -> order ch0x4, ch1x4, ch2x4, ch3x4, ch0x4, ...
//  3 fifo_ready_i held 0 for 10 cycles mid-burst -> fifo_data_o stable, one ch_ready high max, no beat lost/dup.
//  4 ch1 drops valid after 2 beats -> burst ends, next grant ch2 (if valid), beat_cnt restarts at 0.
//  5 cfg_en_i deasserted mid-burst -> burst finishes, then IDLE with ch_ready_o=0 until re-enabled.
//  6 PRIO_EN: ch0 and ch3 valid, rr_ptr=3 -> ch0 granted first; without macro -> ch3 first.
//  7 rstn_i pulsed mid-burst -> all outputs reset values next edge, rr_ptr=0.

Source files
------------

// File: rtl/udma_tx_arb_pkg.sv
// Shared types and helpers for the uDMA TX channel arbiter.
// Holds the FSM state enum, the ID width function and the beat bundle.
package udma_tx_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // Width of an index into n items, never below one bit.
  function automatic int id_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_N_CH   = 4;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ID_W   = id_w(DEF_N_CH);

  // Beat as seen by the dc-fifo for the default channel count and width.
  typedef struct packed {
    logic [DEF_ID_W-1:0]   id;
    logic [DEF_DATA_W-1:0] data;
  } beat_t;

endpackage

// File: rtl/udma_rr_pick.sv
// Rotate-priority encoder: first set request at or after i_ptr, modulo N.
// Ports: i_req (requests), i_ptr (start index), o_idx (winner), o_found.
module udma_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [IW-1:0] o_idx,
  output logic          o_found
);

  // Walk offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[(int'(i_ptr) + i) % N]) begin
        o_idx   = IW'((int'(i_ptr) + i) % N);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/udma_cdc_tx_arbiter.sv
// Round-robin burst-locked arbiter feeding one dc-fifo source port.
// Ports: clk_i/rstn_i, cfg_en_i, ch_{data,last,valid}_i, ch_ready_o,
//   fifo_{data,valid}_o, fifo_ready_i, busy_o, grant_id_o.
// Option: UDMA_TX_ARB_PRIO_EN gives channel 0 fixed priority in IDLE.
module udma_cdc_tx_arbiter
  import udma_tx_arb_pkg::*;
#(
  parameter  int N_CH       = 4,
  parameter  int DATA_WIDTH = 32,
  parameter  int MAX_BURST  = 4,
  localparam int ID_W       = id_w(N_CH)
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          cfg_en_i,
  input  logic [N_CH-1:0][DATA_WIDTH-1:0] ch_data_i,
  input  logic [N_CH-1:0]               ch_last_i,
  input  logic [N_CH-1:0]               ch_valid_i,
  output logic [N_CH-1:0]               ch_ready_o,
  output logic [ID_W+DATA_WIDTH-1:0]    fifo_data_o,
  output logic                          fifo_valid_o,
  input  logic                          fifo_ready_i,
  output logic                          busy_o,
  output logic [ID_W-1:0]               grant_id_o
);

  localparam int CNT_W = id_w(MAX_BURST);

  arb_state_e r_state;
  logic [ID_W-1:0] r_grant;
  logic [ID_W-1:0] r_rr_ptr;
  logic [CNT_W-1:0] r_beat_cnt;
  logic r_out_valid;
  logic [ID_W+DATA_WIDTH-1:0] r_out_data;

  logic [ID_W-1:0] w_pick_idx;
  logic w_pick_found;
  logic [ID_W-1:0] w_win_idx;
  logic w_win_found;
  logic w_load_ok;
  logic w_slot;
  logic w_g_valid;
  logic w_g_last;
  logic w_accept;
  logic w_last_beat;
  logic w_end;
  logic w_upd_ptr;
  logic [ID_W-1:0] w_next_ptr;

  udma_rr_pick #(
    .N  (N_CH),
    .IW (ID_W)
  ) u_pick (
    .i_req   (ch_valid_i),
    .i_ptr   (r_rr_ptr),
    .o_idx   (w_pick_idx),
    .o_found (w_pick_found)
  );

`ifdef UDMA_TX_ARB_PRIO_EN
  // Channel 0 bypasses the rotation and never advances the pointer.
  assign w_win_idx   = ch_valid_i[0] ? '0 : w_pick_idx;
  assign w_win_found = w_pick_found;
  assign w_upd_ptr   = (r_grant != '0);
`else
  assign w_win_idx   = w_pick_idx;
  assign w_win_found = w_pick_found;
  assign w_upd_ptr   = 1'b1;
`endif

  // Output slot is free when empty or being drained this cycle.
  assign w_load_ok = ~r_out_valid | fifo_ready_i;
  assign w_slot    = (r_state == BURST) & w_load_ok;
  assign w_g_valid = ch_valid_i[r_grant];
  assign w_g_last  = ch_last_i[r_grant];
  assign w_accept  = w_slot & w_g_valid;

  assign w_last_beat =
    w_g_last | (r_beat_cnt == CNT_W'(MAX_BURST - 1));

  // A slot with no valid beat from the owner also closes the burst.
  assign w_end = w_slot & (~w_g_valid | w_last_beat);

  assign w_next_ptr = (r_grant == ID_W'(N_CH - 1))
                    ? '0
                    : r_grant + ID_W'(1);

  always_comb begin
    ch_ready_o = '0;
    if (w_slot) ch_ready_o[r_grant] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_rr_ptr    <= '0;
      r_beat_cnt  <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      if (w_load_ok) begin
        r_out_valid <= w_accept;
        if (w_accept) begin
          r_out_data <= {r_grant, ch_data_i[r_grant]};
        end
      end
      unique case (r_state)
        IDLE: begin
          if (cfg_en_i & w_win_found) begin
            r_grant    <= w_win_idx;
            r_beat_cnt <= '0;
            r_state    <= BURST;
          end
        end
        BURST: begin
          if (w_accept) begin
            r_beat_cnt <= r_beat_cnt + CNT_W'(1);
          end
          if (w_end) begin
            r_state    <= IDLE;
            r_beat_cnt <= '0;
            if (w_upd_ptr) r_rr_ptr <= w_next_ptr;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign fifo_valid_o = r_out_valid;
  assign fifo_data_o  = r_out_data;
  assign busy_o       = (r_state == BURST) | r_out_valid;
  assign grant_id_o   = r_grant;

endmodule

// File: tb/tb_udma_cdc_tx_arbiter.sv
// Directed bench for udma_cdc_tx_arbiter (4 ch, 32b, burst 4).
// Per-channel sources and an output log checked against hand tables.
module tb_udma_cdc_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rstn_i;
  logic cfg_en_i;
  logic [N-1:0][DW-1:0] ch_data_i;
  logic [N-1:0] ch_last_i;
  logic [N-1:0] ch_valid_i;
  logic [N-1:0] ch_ready_o;
  logic [IW+DW-1:0] fifo_data_o;
  logic fifo_valid_o;
  logic fifo_ready_i;
  logic busy_o;
  logic [IW-1:0] grant_id_o;

  udma_cdc_tx_arbiter #(
    .N_CH       (N),
    .DATA_WIDTH (DW),
    .MAX_BURST  (4)
  ) dut (
    .clk_i        (clk),
    .rstn_i       (rstn_i),
    .cfg_en_i     (cfg_en_i),
    .ch_data_i    (ch_data_i),
    .ch_last_i    (ch_last_i),
    .ch_valid_i   (ch_valid_i),
    .ch_ready_o   (ch_ready_o),
    .fifo_data_o  (fifo_data_o),
    .fifo_valid_o (fifo_valid_o),
    .fifo_ready_i (fifo_ready_i),
    .busy_o       (busy_o),
    .grant_id_o   (grant_id_o)
  );

  always #5 clk = ~clk;

  int rem [N];
  int seq [N];
  bit lastm [N];
  bit hs [N];
  logic [IW+DW-1:0] out_q [$];
  int ec [$];
  int en [$];
  int viol;
  int checks;
  int errors;

  always_comb begin
    for (int c = 0; c < N; c++) begin
      ch_valid_i[c] = (rem[c] != 0);
      ch_last_i[c]  = lastm[c] && (rem[c] == 1);
      ch_data_i[c]  = 32'hC000_0000
                    | (32'(c) << 16)
                    | 32'(seq[c]);
    end
  end

  always @(negedge clk) begin
    for (int c = 0; c < N; c++) begin
      hs[c] = rstn_i & ch_valid_i[c] & ch_ready_o[c];
    end
    if (rstn_i & fifo_valid_o & fifo_ready_i) begin
      out_q.push_back(fifo_data_o);
    end
    if ($countones(ch_ready_o) > 1) viol++;
  end

  always @(posedge clk) begin
    #2;
    for (int c = 0; c < N; c++) begin
      if (hs[c] && rem[c] != 0) begin
        rem[c]--;
        seq[c]++;
      end
      hs[c] = 1'b0;
    end
  end

  function automatic logic [IW+DW-1:0] eb(input int c, input int n);
    logic [DW-1:0] d;
    d = 32'hC000_0000 | (32'(c) << 16) | 32'(n);
    return {c[IW-1:0], d};
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input int c, input int n, input bit l);
    seq[c]   = 0;
    lastm[c] = l;
    rem[c]   = n;
  endtask

  task automatic clr_src();
    for (int c = 0; c < N; c++) begin
      rem[c]   = 0;
      seq[c]   = 0;
      lastm[c] = 1'b0;
    end
  endtask

  task automatic do_reset();
    tick(1);
    rstn_i = 1'b0;
    clr_src();
    tick(2);
    rstn_i = 1'b1;
    out_q.delete();
    tick(1);
  endtask

  task automatic wait_fv(input string tag);
    int k;
    k = 0;
    while (!fifo_valid_o && k < 50) begin
      tick(1);
      k++;
    end
    chk(tag, 64'(fifo_valid_o), 64'd1);
  endtask

  task automatic wait_q(input string tag, input int n);
    int k;
    k = 0;
    while (out_q.size() < n && k < 200) begin
      tick(1);
      k++;
    end
    tick(8);
    chk(tag, 64'(out_q.size()), 64'(n));
  endtask

  task automatic xp(input int c, input int n);
    ec.push_back(c);
    en.push_back(n);
  endtask

  task automatic chk_seq(input string tag);
    logic [IW+DW-1:0] got;
    for (int i = 0; i < ec.size(); i++) begin
      got = (i < out_q.size()) ? out_q[i] : '0;
      chk($sformatf("%s_%0d", tag, i), 64'(got),
          64'(eb(ec[i], en[i])));
    end
    ec.delete();
    en.delete();
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_fv"}, 64'(fifo_valid_o), 64'd0);
    chk({tag, "_fd"}, 64'(fifo_data_o), 64'd0);
    chk({tag, "_rdy"}, 64'(ch_ready_o), 64'd0);
    chk({tag, "_busy"}, 64'(busy_o), 64'd0);
    chk({tag, "_gnt"}, 64'(grant_id_o), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    checks       = 0;
    errors       = 0;
    viol         = 0;
    cfg_en_i     = 1'b1;
    fifo_ready_i = 1'b1;
    clr_src();
    rstn_i = 1'b1;
    #1;
    rstn_i = 1'b0;
    tick(3);
    chk_rst("rst");
    rstn_i = 1'b1;
    tick(1);

    // single ch2 transfer, last on third beat
    load(2, 3, 1'b1);
    wait_q("t1_cnt", 3);
    xp(2, 0); xp(2, 1); xp(2, 2);
    chk_seq("t1");
    chk("t1_busy", 64'(busy_o), 64'd0);
    chk("t1_gnt", 64'(grant_id_o), 64'd2);
    chk("t1_fv", 64'(fifo_valid_o), 64'd0);

    // rr_ptr is 3 here: ch3 wins unless ch0 has priority
    out_q.delete();
    load(0, 1, 1'b1);
    load(3, 1, 1'b1);
    wait_q("t6_cnt", 2);
`ifdef UDMA_TX_ARB_PRIO_EN
    xp(0, 0); xp(3, 0);
    chk("t6_gnt", 64'(grant_id_o), 64'd3);
`else
    xp(3, 0); xp(0, 0);
    chk("t6_gnt", 64'(grant_id_o), 64'd0);
`endif
    chk_seq("t6");

    // all channels streaming, max bursts
    do_reset();
    for (int c = 0; c < N; c++) load(c, 8, 1'b0);
    wait_q("t2_cnt", 32);
`ifdef UDMA_TX_ARB_PRIO_EN
    for (int k = 0; k < 8; k++) xp(0, k);
    for (int b = 0; b < 6; b++) begin
      for (int k = 0; k < 4; k++) begin
        xp(1 + (b % 3), (b / 3) * 4 + k);
      end
    end
`else
    for (int b = 0; b < 8; b++) begin
      for (int k = 0; k < 4; k++) begin
        xp(b % 4, (b / 4) * 4 + k);
      end
    end
`endif
    chk_seq("t2");

    // back-pressure holds the beat and blocks the channel
    do_reset();
    load(1, 4, 1'b1);
    wait_fv("t3_fv");
    fifo_ready_i = 1'b0;
    tick(10);
    chk("t3_hold", 64'(fifo_data_o), 64'(eb(1, 0)));
    chk("t3_rdy", 64'(ch_ready_o), 64'd0);
    chk("t3_busy", 64'(busy_o), 64'd1);
    chk("t3_gnt", 64'(grant_id_o), 64'd1);
    fifo_ready_i = 1'b1;
    wait_q("t3_cnt", 4);
    for (int k = 0; k < 4; k++) xp(1, k);
    chk_seq("t3");

    // ch1 drops valid early; ch2 gets a fresh count
    do_reset();
    load(1, 2, 1'b0);
    load(2, 5, 1'b0);
    load(3, 1, 1'b1);
    wait_q("t4_cnt", 8);
    xp(1, 0); xp(1, 1);
    xp(2, 0); xp(2, 1); xp(2, 2); xp(2, 3);
    xp(3, 0); xp(2, 4);
    chk_seq("t4");

    // disable mid-burst: burst completes, no new grant
    out_q.delete();
    load(0, 4, 1'b0);
    load(1, 2, 1'b1);
    wait_fv("t5_fv");
    cfg_en_i = 1'b0;
    tick(15);
    chk("t5_cnt", 64'(out_q.size()), 64'd4);
    chk("t5_rdy", 64'(ch_ready_o), 64'd0);
    chk("t5_busy", 64'(busy_o), 64'd0);
    chk("t5_gnt", 64'(grant_id_o), 64'd0);
    cfg_en_i = 1'b1;
    wait_q("t5_cnt2", 6);
    for (int k = 0; k < 4; k++) xp(0, k);
    xp(1, 0); xp(1, 1);
    chk_seq("t5");

    // reset mid-burst, then rr_ptr must be 0 again
    out_q.delete();
    load(3, 4, 1'b0);
    wait_fv("t7_fv");
    rstn_i = 1'b0;
    #1;
    chk_rst("t7");
    clr_src();
    tick(2);
    rstn_i = 1'b1;
    out_q.delete();
    tick(1);
    load(1, 1, 1'b1);
    load(3, 1, 1'b1);
    wait_q("t7_cnt", 2);
    xp(1, 0); xp(3, 0);
    chk_seq("t7");

    chk("onehot", 64'(viol), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
